// File: rtl/nand_share_sched_if.sv
// ============================================================================
// Module      : nand_share_sched_if
// Description : Request/operand/result bundle between issuers and the shared
//               NAND scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nand_share_sched_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_bus;
  logic [N*WIDTH-1:0] b_bus;
  logic [N-1:0]       gnt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;
  logic [IDW-1:0]     out_id;

  modport master (
    output req, a_bus, b_bus,
    input  gnt, busy, done, out, out_id
  );

  modport slave (
    input  req, a_bus, b_bus,
    output gnt, busy, done, out, out_id
  );
endinterface

`default_nettype wire

// File: rtl/nand_share_sched.sv
// ============================================================================
// Module      : nand_share_sched
// Description : Round-robin scheduler sharing one 1-bit NAND gate between N
//               requesters; operands are evaluated bit-serially, LSB first.
//               Optional macro NAND_SHARE_OPCNT_EN adds a 16-bit op_count port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_share_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_share_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_share_sched_if.slave    bus
`ifdef NAND_SHARE_OPCNT_EN
  ,
  output logic [15:0]          op_count
`endif
);
  localparam int IDW = $clog2(N);
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  C_LAST  = CW'(WIDTH - 1);
  localparam logic [IDW-1:0] C_MAXID = IDW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             nand_y;

  // Scan from ptr upward with modulo-N wrap; first set request wins.
  always_comb begin : arb_scan
    int             idx;
    logic [IDW-1:0] idx_v;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_v      = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      idx_v = IDW'(idx);
      if (!pick_found && bus.req[idx_v]) begin
        pick_found = 1'b1;
        pick_idx   = idx_v;
      end
    end
  end

  nand_share_cell u_nand (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .y (nand_y)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    done_d   = 1'b0;
    out_d    = out_q;
    out_id_d = out_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          cnt_d   = '0;
          a_sh_d  = bus.a_bus[pick_idx*WIDTH +: WIDTH];
          b_sh_d  = bus.b_bus[pick_idx*WIDTH +: WIDTH];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Result fills from the MSB so bit k lands in place after WIDTH shifts.
        res_d  = (res_q >> 1) | (WIDTH'(nand_y) << (WIDTH - 1));
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          out_d    = res_d;
          out_id_d = win_q;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == C_MAXID) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      out_q    <= '0;
      out_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      done_q   <= done_d;
      out_q    <= out_d;
      out_id_q <= out_id_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.out    = out_q;
  assign bus.out_id = out_id_q;

`ifdef NAND_SHARE_OPCNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (done_q) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/nand_share_sched.md
Name: nand_share_sched

Overview:
- Scheduler that shares one 1-bit two-input NAND gate between N requesters.
- Each requester presents two WIDTH-bit operands. A round-robin arbiter grants one requester at a time.
- The granted operation is evaluated bit-serially through the single gate, LSB first, then returned with the winner's id.
- Sits between gate-level structural datapath blocks and the bench/top that issues logic operations.

Parameters:
- N, 4, number of requesters (legal range 2..16).
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- IDW, $clog2(N), width of the requester-id output (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester request; bit i is requester i.
- a_bus  input  N*WIDTH  operand A; slice [i*WIDTH +: WIDTH] belongs to requester i.
- b_bus  input  N*WIDTH  operand B, same slicing as a_bus.
- gnt  output  N  one-hot grant, held for the whole operation.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse; result valid.
- out  output  WIDTH  bitwise NAND of the granted A and B.
- out_id  output  IDW  index of the requester whose result is on out.

Interface (already decided):
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt=0, busy=0, done=0, out=0, out_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Bit counter=0; operand shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit scanning from index ptr upward, with modulo-N wrap.
  - Latch that requester's A and B slices into shift registers; set gnt one-hot and cnt=0; go to SHIFT.
  - busy and gnt rise in the cycle after the capturing edge.
- SHIFT (one bit per clock):
  - Evaluate y = ~(a_sh[0] & b_sh[0]) through one 1-bit NAND instance (the only logic gate evaluated).
  - Shift y into the result register MSB-first-in, so after WIDTH shifts bit k of out equals NAND of bit k.
  - Shift a_sh and b_sh right by 1; cnt++.
  - When cnt reaches WIDTH-1, the edge processing the last bit moves to DONE.
  - State occupies exactly WIDTH cycles.
- DONE (one cycle):
  - done=1, out=result, out_id=winner index; gnt stays asserted.
  - ptr=(winner+1) mod N.
  - Next edge: gnt=0, done=0, go to IDLE.
- Latency: done is high exactly WIDTH+1 cycles after the capture edge.
- Throughput: one operation per WIDTH+2 cycles. There is no IDLE bypass; there is always one IDLE cycle between operations.
- out/out_id hold their last value until the next DONE. They do not clear on IDLE.
- Operands are sampled only at the capture edge. Changes to a_bus/b_bus during SHIFT are ignored.
- req deasserted mid-operation: the operation still completes and done still pulses. The requester is expected to hold req until it sees done with its gnt bit.
- Simultaneous requests: exactly one grant per operation. Losers remain pending; no request is dropped or queued internally.
- Fairness: a continuously requesting requester is granted within N operations.
- Single requester asserting req continuously: re-granted every WIDTH+2 cycles.
- rst_n asserted mid-SHIFT or mid-DONE: immediate return to reset values; no done pulse; partial result discarded.
- gnt is always zero or one-hot; busy equals (state!=IDLE).

Optional Feature:
- Macro: NAND_SHARE_OPCNT_EN.
- Defined:
  - Adds output port op_count (16 bits), reset 0.
  - op_count increments by 1 on every cycle done is high; wraps 16'hFFFF -> 0.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 for 10 cycles -> gnt=0, busy=0, done=0, out=0, out_id=0 throughout.
- Single op, N=4, WIDTH=8: req=4'b0100, A2=8'hF0, B2=8'hCC -> gnt=4'b0100 from next cycle; done high 9 cycles after capture; out=8'h3F, out_id=2.
- Round-robin: req=4'b1111 held, A_i=B_i=8'h00 -> grant order 0,1,2,3,0; each done has out=8'hFF; ops spaced 10 cycles apart.
- Operand change and req drop mid-op: req0 with A0=8'hFF, B0=8'hFF; after capture, change A0 to 8'h00 and drop req0 -> done still pulses with out=8'h00, out_id=0.
- Reset mid-op: assert rst_n low during SHIFT cycle 4 -> all outputs zero immediately, no done. After release, req=4'b1000 is granted first.
- NAND_SHARE_OPCNT_EN defined: 3 completed ops -> op_count=3; reset -> 0.
